// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the add/sub datapath: steps each instruction through
// FETCH/DECODE/EXECUTE/WRITEBACK, drives datapath enables and counts retirements.
`ifndef ADD
`define ADD  4'h2
`endif
`ifndef ADDU
`define ADDU 4'h3
`endif
`ifndef SUB
`define SUB  4'h6
`endif
`ifndef SUBU
`define SUBU 4'h7
`endif
`ifndef NOP
`define NOP  4'h0
`endif

module multicycle_controller #(
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      instr,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_dst,
    output logic             alu_src_b,
    output logic             reg_write,
    output logic [3:0]       alu_op,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam int               WAIT_W    = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [5:0]        opcode_r;
    logic [5:0]        funct_r;
    logic              zero_word_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  retired_r;
    logic              retire_s;
    logic [5:0]        alu_ctrl_s;

    // Only the add/sub R-type functs and ADDI/ADDIU are executable.
    function automatic logic is_supported(input logic [5:0] opc, input logic [5:0] fn);
        logic ok;
        case (opc)
            6'h00:   ok = (fn == 6'h20) || (fn == 6'h21) || (fn == 6'h22) || (fn == 6'h23);
            6'h08:   ok = 1'b1;
            6'h09:   ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns {alu_op, reg_dst, alu_src_b} for the latched instruction fields.
    function automatic logic [5:0] alu_ctrl(input logic [5:0] opc, input logic [5:0] fn);
        logic [5:0] c;
        case (opc)
            6'h00: begin
                case (fn)
                    6'h20:   c = {`ADD,  1'b0, 1'b0};
                    6'h21:   c = {`ADDU, 1'b0, 1'b0};
                    6'h22:   c = {`SUB,  1'b0, 1'b0};
                    6'h23:   c = {`SUBU, 1'b0, 1'b0};
                    default: c = {`NOP,  1'b0, 1'b0};
                endcase
            end
            6'h08:   c = {`ADD,  1'b1, 1'b1};
            6'h09:   c = {`ADDU, 1'b1, 1'b1};
            default: c = {`NOP,  1'b0, 1'b0};
        endcase
        return c;
    endfunction

    // State register
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; the unused encoding falls into FAULT
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:   state_nx_s = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (imem_ready) begin
                    state_nx_s = S_DECODE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nx_s = S_FAULT;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (zero_word_r) begin
                    state_nx_s = S_FETCH;
                end else if (opcode_r == 6'h3F) begin
                    state_nx_s = S_HALT;
                end else if (is_supported(opcode_r, funct_r)) begin
                    state_nx_s = S_EXEC;
                end else begin
                    state_nx_s = S_FAULT;
                end
            end
            S_EXEC:   state_nx_s = S_WB;
            S_WB:     state_nx_s = S_FETCH;
            S_HALT:   state_nx_s = S_HALT;
            S_FAULT:  state_nx_s = S_FAULT;
            default:  state_nx_s = S_FAULT;
        endcase
    end

    // Instruction field latches and fetch wait counter
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            opcode_r    <= 6'd0;
            funct_r     <= 6'd0;
            zero_word_r <= 1'b0;
            wait_cnt_r  <= '0;
        end else if (state_r == S_FETCH) begin
            if (imem_ready) begin
                opcode_r    <= instr[31:26];
                funct_r     <= instr[5:0];
                zero_word_r <= (instr == 32'd0);
                wait_cnt_r  <= '0;
            end else begin
                wait_cnt_r  <= wait_cnt_r + WAIT_W'(1);
            end
        end else begin
            wait_cnt_r <= '0;
        end
    end

    assign retire_s = (state_r == S_WB) || ((state_r == S_DECODE) && zero_word_r);

    // Retired-instruction counter, saturating at all-ones
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            retired_r <= '0;
        end else if (retire_s && (retired_r != {CNT_W{1'b1}})) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    assign alu_ctrl_s = alu_ctrl(opcode_r, funct_r);

    // Output decode; ir/pc writes follow imem_ready combinationally in FETCH
    always_comb begin
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_dst   = 1'b0;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        alu_op    = `NOP;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_EXEC, S_WB: begin
                alu_op    = alu_ctrl_s[5:2];
                reg_dst   = alu_ctrl_s[1];
                alu_src_b = alu_ctrl_s[0];
                reg_write = (state_r == S_WB);
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    assign retired = retired_r;
    assign state   = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: a per-instruction trace model predicts every cycle's outputs.
module tb_multicycle_controller;

    localparam int FT = 15;
    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_ADDU = 4'h3;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SUBU = 4'h7;
    localparam logic [31:0] JUNK    = 32'hDEADBEEF;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        start = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        imem_req, ir_write, pc_write, reg_dst, alu_src_b, reg_write, halted, fault;
    logic [3:0]  alu_op;
    logic [15:0] retired;
    logic [2:0]  state;

    multicycle_controller #(.CNT_W(16), .FETCH_TIMEOUT(FT)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .start(start), .imem_req(imem_req),
        .imem_ready(imem_ready), .instr(instr), .ir_write(ir_write), .pc_write(pc_write),
        .reg_dst(reg_dst), .alu_src_b(alu_src_b), .reg_write(reg_write), .alu_op(alu_op),
        .retired(retired), .halted(halted), .fault(fault), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  st;
        logic        req, irw, pcw, dst, srcb, rw;
        logic [3:0]  op;
        logic [15:0] ret;
        logic        hlt, flt;
    } obs_t;

    typedef struct packed {
        logic        start;
        logic        ready;
        logic [31:0] instr;
    } stim_t;

    obs_t  exp_q[$];
    stim_t stim_q[$];
    obs_t  exp_cur;
    obs_t  dut_obs;
    bit    exp_valid = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    m_ret = 0;
    int    rw_pulses = 0;

    assign dut_obs = {state, imem_req, ir_write, pc_write, reg_dst, alu_src_b, reg_write,
                      alu_op, retired, halted, fault};

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_valid) check_val("cycle_trace", 64'(dut_obs), 64'(exp_cur));
    end

    always @(negedge CLK) begin
        if (reg_write === 1'b1) rw_pulses++;
    end

    function automatic obs_t mk(input logic [2:0] st, input logic req, input logic irw,
                                input logic pcw, input logic dst, input logic srcb,
                                input logic rw, input logic [3:0] op, input logic hlt,
                                input logic flt);
        return {st, req, irw, pcw, dst, srcb, rw, op, 16'(m_ret), hlt, flt};
    endfunction

    function automatic stim_t mk_stim(input logic s, input logic r, input logic [31:0] w);
        return {s, r, w};
    endfunction

    task automatic push(input stim_t s, input obs_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // kind: 0 = NOP word, 1 = ALU op, 2 = halt, 3 = unsupported
    task automatic classify(input logic [31:0] w, output int kind, output logic [3:0] op,
                            output logic dst, output logic srcb);
        kind = 3; op = ALU_NOP; dst = 1'b0; srcb = 1'b0;
        if (w == 32'd0) kind = 0;
        else if (w[31:26] == 6'h3F) kind = 2;
        else if (w[31:26] == 6'h08) begin kind = 1; op = ALU_ADD;  dst = 1'b1; srcb = 1'b1; end
        else if (w[31:26] == 6'h09) begin kind = 1; op = ALU_ADDU; dst = 1'b1; srcb = 1'b1; end
        else if (w[31:26] == 6'h00) begin
            if (w[5:0] == 6'h20) begin kind = 1; op = ALU_ADD;  end
            if (w[5:0] == 6'h21) begin kind = 1; op = ALU_ADDU; end
            if (w[5:0] == 6'h22) begin kind = 1; op = ALU_SUB;  end
            if (w[5:0] == 6'h23) begin kind = 1; op = ALU_SUBU; end
        end
    endtask

    // Terminal states: start and ready are toggled but must change nothing
    task automatic gen_dead(input bit is_halt);
        for (int i = 0; i < 4; i++)
            push(mk_stim(1'b1, 1'b1, 32'h00221820),
                 is_halt ? mk(3'd5, 0, 0, 0, 0, 0, 0, ALU_NOP, 1, 0)
                         : mk(3'd6, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 1));
    endtask

    task automatic gen_start();
        push(mk_stim(1'b1, 1'b0, JUNK), mk(3'd0, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
    endtask

    task automatic gen_instr(input logic [31:0] w, input int waits);
        int kind; logic [3:0] op; logic dst, srcb;
        for (int i = 0; i < waits && i < FT; i++)
            push(mk_stim(1'b0, 1'b0, 32'hFC000000), mk(3'd1, 1, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
        if (waits >= FT) begin
            gen_dead(1'b0);
            return;
        end
        push(mk_stim(1'b0, 1'b1, w), mk(3'd1, 1, 1, 1, 0, 0, 0, ALU_NOP, 0, 0));
        push(mk_stim(1'b1, 1'b1, JUNK), mk(3'd2, 0, 0, 0, 0, 0, 0, ALU_NOP, 0, 0));
        classify(w, kind, op, dst, srcb);
        case (kind)
            0: if (m_ret < 65535) m_ret++;
            1: begin
                push(mk_stim(1'b0, 1'b1, JUNK), mk(3'd3, 0, 0, 0, dst, srcb, 0, op, 0, 0));
                push(mk_stim(1'b0, 1'b1, JUNK), mk(3'd4, 0, 0, 0, dst, srcb, 1, op, 0, 0));
                if (m_ret < 65535) m_ret++;
            end
            2: gen_dead(1'b1);
            default: gen_dead(1'b0);
        endcase
    endtask

    task automatic run();
        stim_t s;
        while (stim_q.size() > 0) begin
            @(posedge CLK); #1;
            s = stim_q.pop_front();
            start = s.start; imem_ready = s.ready; instr = s.instr;
            exp_cur = exp_q.pop_front();
            exp_valid = 1'b1;
        end
        @(posedge CLK); #1;
        exp_valid = 1'b0;
        start = 1'b0; imem_ready = 1'b0; instr = 32'd0;
    endtask

    task automatic do_reset();
        Reset_L = 1'b0; start = 1'b1; imem_ready = 1'b1; instr = 32'h00221820;
        m_ret = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_state", 64'(state), 64'd0);
        check_val("rst_bits", 64'({imem_req, ir_write, pc_write, reg_dst, alu_src_b,
                                    reg_write, halted, fault}), 64'd0);
        check_val("rst_alu_op", 64'(alu_op), 64'(ALU_NOP));
        check_val("rst_retired", 64'(retired), 64'd0);
        start = 1'b0; imem_ready = 1'b0; instr = 32'd0;
        rw_pulses = 0;
        Reset_L = 1'b1;
    endtask

    initial begin
        // Single add with always-ready memory
        do_reset();
        gen_start(); gen_instr(32'h00221820, 0); run();
        check_val("t1_retired", 64'(retired), 64'd1);
        check_val("t1_rw_pulses", 64'(rw_pulses), 64'd1);

        // addi, addiu, subu then halt
        do_reset();
        gen_start();
        gen_instr(32'h20220005, 0); gen_instr(32'h24220005, 0);
        gen_instr(32'h00221823, 0); gen_instr(32'hFC000000, 0);
        run();
        check_val("t2_retired", 64'(retired), 64'd3);
        check_val("t2_halted", 64'(halted), 64'd1);
        check_val("t2_no_req", 64'(imem_req), 64'd0);
        check_val("t2_rw_pulses", 64'(rw_pulses), 64'd3);

        // Three wait cycles before ready
        do_reset();
        gen_start(); gen_instr(32'h00221822, 3); run();
        check_val("t3_retired", 64'(retired), 64'd1);
        check_val("t3_fault", 64'(fault), 64'd0);

        // Memory never ready -> timeout fault
        do_reset();
        gen_start(); gen_instr(32'h00221820, 100); run();
        check_val("t4_fault", 64'(fault), 64'd1);
        check_val("t4_state", 64'(state), 64'd6);
        check_val("t4_rw_pulses", 64'(rw_pulses), 64'd0);

        // Ready on the last permitted cycle still wins
        do_reset();
        gen_start(); gen_instr(32'h00221820, FT - 1); gen_instr(32'h24220005, 0); run();
        check_val("t5_retired", 64'(retired), 64'd2);
        check_val("t5_fault", 64'(fault), 64'd0);

        // NOP word retires, unsupported funct faults from DECODE
        do_reset();
        gen_start(); gen_instr(32'h00000000, 0); gen_instr(32'h00221824, 0); run();
        check_val("t6_retired", 64'(retired), 64'd1);
        check_val("t6_fault", 64'(fault), 64'd1);
        check_val("t6_rw_pulses", 64'(rw_pulses), 64'd0);

        // Reset asserted during WRITEBACK of an add
        do_reset();
        gen_start(); gen_instr(32'h00000000, 0); gen_instr(32'h00221820, 0);
        void'(stim_q.pop_back()); void'(exp_q.pop_back());
        run();
        check_val("t7_in_wb", 64'(state), 64'd4);
        check_val("t7_ret_before", 64'(retired), 64'd1);
        Reset_L = 1'b0;
        #1;
        check_val("t7_state", 64'(state), 64'd0);
        check_val("t7_reg_write", 64'(reg_write), 64'd0);
        check_val("t7_alu_op", 64'(alu_op), 64'(ALU_NOP));
        check_val("t7_retired", 64'(retired), 64'd0);
        do_reset();
        gen_start(); gen_instr(32'h00221821, 0); run();
        check_val("t7_resume_retired", 64'(retired), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
